led_display_scan: RTL

Parametrised multiplexed 7-segment/LED-digit scan controller with tear-free frame snapshots, inter-digit blanking, PWM brightness and per-digit blink. It sits between the application's digit registers and the board's shared segment and digit-select pins. It drives one digit per time slot, cycling through all digits in order 0..NUM-1.

---
 rtl/led_display_scan.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/led_display_scan.sv
// Multiplexed LED-digit scan controller: one digit per time slot with a blanking
// dead-time, PWM brightness, per-digit blink and frame-aligned input snapshots.
//
// state    | meaning
// ST_BLANK | dead-time at slot start, all digits deselected, segments off
// ST_DRIVE | current digit selected, gated by PWM and blink
module led_display_scan #(
    parameter int   NUM          = 4,
    parameter logic SEG_ACTIVE   = 1'b0,
    parameter logic SEL_ACTIVE   = 1'b0,
    parameter int   CLK_CYCLE    = 1000,
    parameter int   BLANK_CYCLE  = 16,
    parameter int   BLINK_FRAMES = 250
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic [NUM-1:0][7:0] led_in,
    input  logic [NUM-1:0]      blink_en,
    input  logic [4:0]          bright,
    output logic [7:0]          led_display_seg,
    output logic [NUM-1:0]      led_display_sel,
    output logic                frame_start
);

    localparam int SW = $clog2(CLK_CYCLE);
    localparam int DW = $clog2(NUM);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0]  SLOT_LAST  = SW'(CLK_CYCLE - 1);
    localparam logic [SW-1:0]  BLANK_LAST = SW'(BLANK_CYCLE - 1);
    localparam logic [DW-1:0]  DIGIT_LAST = DW'(NUM - 1);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]     SEG_OFF    = {8{~SEG_ACTIVE}};
    localparam logic [NUM-1:0] SEL_OFF    = {NUM{~SEL_ACTIVE}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } phase_t;

    phase_t               phase_q, phase_d;
    logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]        digit_q, digit_d;
    logic [3:0]           pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
    logic                 blink_phase_q, blink_phase_d;

    logic [NUM-1:0][7:0]  led_sh_q, led_sh_d;
    logic [NUM-1:0]       blink_sh_q, blink_sh_d;
    logic [4:0]           bright_sh_q, bright_sh_d;

    logic [7:0]           seg_q, seg_d;
    logic [NUM-1:0]       sel_q, sel_d;
    logic                 frame_start_q, frame_start_d;

    logic                 slot_wrap;
    logic                 frame_wrap;
    logic                 snap;
    logic                 lit;
    logic                 blink_off;

    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_wrap = slot_wrap && (digit_q == DIGIT_LAST);
        snap       = enable && (slot_cnt_q == '0) && (digit_q == '0);
        lit        = bright_sh_q[4] || ({1'b0, pwm_cnt_q} < bright_sh_q);
        blink_off  = blink_phase_q && blink_sh_q[digit_q];

        phase_d       = phase_q;
        slot_cnt_d    = slot_cnt_q;
        digit_d       = digit_q;
        pwm_cnt_d     = pwm_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        led_sh_d      = led_sh_q;
        blink_sh_d    = blink_sh_q;
        bright_sh_d   = bright_sh_q;
        seg_d         = SEG_OFF;
        sel_d         = SEL_OFF;
        frame_start_d = snap;

        if (snap) begin
            led_sh_d    = led_in;
            blink_sh_d  = blink_en;
            bright_sh_d = bright;
        end

        if (enable) begin
            slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
            if (slot_wrap) begin
                digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
            end

            case (phase_q)
                ST_BLANK: if (slot_cnt_q == BLANK_LAST) phase_d = ST_DRIVE;
                ST_DRIVE: if (slot_wrap) phase_d = ST_BLANK;
                default:  phase_d = ST_BLANK;
            endcase

            // Held at zero through BLANK so the first DRIVE cycle sees pwm_cnt = 0.
            pwm_cnt_d = (phase_q == ST_DRIVE) ? pwm_cnt_q + 4'd1 : 4'd0;

            // Frame count advances on the wrap into the next frame; a restart
            // after enable re-assertion begins a frame without advancing it.
            if (frame_wrap) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end

            if ((phase_q == ST_DRIVE) && lit) begin
                sel_d[digit_q] = SEL_ACTIVE;
                seg_d          = blink_off ? SEG_OFF : (led_sh_q[digit_q] ^ SEG_OFF);
            end
        end else begin
            phase_d    = ST_BLANK;
            slot_cnt_d = '0;
            digit_d    = '0;
            pwm_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q       <= ST_BLANK;
            slot_cnt_q    <= '0;
            digit_q       <= '0;
            pwm_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_sh_q      <= '0;
            blink_sh_q    <= '0;
            bright_sh_q   <= '0;
            seg_q         <= SEG_OFF;
            sel_q         <= SEL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            pwm_cnt_q     <= pwm_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_sh_q      <= led_sh_d;
            blink_sh_q    <= blink_sh_d;
            bright_sh_q   <= bright_sh_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign led_display_seg = seg_q;
    assign led_display_sel = sel_q;
    assign frame_start     = frame_start_q;

endmodule
